// File: rtl/regincr_window_accum_pkg.sv
// Shared types and default widths for the window accumulator.
package regincr_accum_pkg;

   // Window FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DATA_W_DEF = 8;
   localparam int SUM_W_DEF  = 16;

endpackage

// File: rtl/regincr_window_accum_if.sv
// Input sample stream and window result handshake bundle.
interface regincr_window_accum_if
   import regincr_accum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int SUM_W  = SUM_W_DEF
);
   logic              in_val;
   logic              in_rdy;
   logic [DATA_W-1:0] in_msg;
   logic              out_val;
   logic              out_rdy;
   logic [SUM_W-1:0]  out_sum;
   logic [DATA_W-1:0] out_max;
   logic              busy;

   // Producer of samples and consumer of results.
   modport master (
      output in_val, in_msg, out_rdy,
      input  in_rdy, out_val, out_sum, out_max, busy
   );

   // The accumulator itself.
   modport slave (
      input  in_val, in_msg, out_rdy,
      output in_rdy, out_val, out_sum, out_max, busy
   );
endinterface

// File: rtl/regincr_window_accum.sv
// Accumulates WIN accepted samples, then presents their sum and maximum.
module regincr_window_accum
   import regincr_accum_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int WIN    = 4,
   parameter int SUM_W  = SUM_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   regincr_window_accum_if.slave  bus
);

   localparam logic [7:0] WIN_CNT = 8'(WIN);

   if (WIN < 1 || WIN > 255) begin : g_bad_win
      $error("regincr_window_accum: WIN must be in 1..255");
   end
   if (SUM_W < DATA_W + $clog2(WIN)) begin : g_bad_sum_w
      $error("regincr_window_accum: SUM_W too narrow for WIN samples");
   end

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [DATA_W-1:0] max_q, max_d;
   logic              out_val_q;
   logic              busy_q;
   logic              in_fire;
   logic              out_fire;

   // While a result is pending, a new sample may only enter when that result
   // leaves in the same cycle, so in_rdy follows out_rdy combinationally.
   assign bus.in_rdy  = (state_q == DONE) ? bus.out_rdy : 1'b1;
   assign in_fire     = bus.in_val && bus.in_rdy;
   assign out_fire    = out_val_q && bus.out_rdy;

   assign bus.out_val = out_val_q;
   assign bus.busy    = busy_q;
   assign bus.out_sum = sum_q;
   assign bus.out_max = max_q;

   // Next-state and datapath update; DONE holds its result until it is taken.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      max_d   = max_q;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               cnt_d   = 8'd1;
               sum_d   = SUM_W'(bus.in_msg);
               max_d   = bus.in_msg;
               state_d = (WIN_CNT == 8'd1) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (in_fire) begin
               cnt_d = cnt_q + 8'd1;
               sum_d = sum_q + SUM_W'(bus.in_msg);
               if (bus.in_msg > max_q) begin
                  max_d = bus.in_msg;
               end
               state_d = (cnt_d == WIN_CNT) ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (out_fire) begin
               if (in_fire) begin
                  // Result leaves while the sample opens the next window.
                  cnt_d   = 8'd1;
                  sum_d   = SUM_W'(bus.in_msg);
                  max_d   = bus.in_msg;
                  state_d = (WIN_CNT == 8'd1) ? DONE : ACCUM;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered status flags; reset discards any window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         sum_q     <= '0;
         max_q     <= '0;
         out_val_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         max_q     <= max_d;
         out_val_q <= (state_d == DONE);
         busy_q    <= (state_d == ACCUM);
      end
   end

endmodule

// File: tb/tb_regincr_window_accum.sv
// Scoreboard bench: a WIN=4 instance and a WIN=1 instance.
module tb_regincr_window_accum;

   typedef struct {
      int sum;
      int max;
   } exp_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   exp_t q0[$];
   exp_t q1[$];

   regincr_window_accum_if #(.DATA_W(8), .SUM_W(16)) bus0 ();
   regincr_window_accum_if #(.DATA_W(8), .SUM_W(16)) bus1 ();

   regincr_window_accum #(.DATA_W(8), .WIN(4), .SUM_W(16)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0.slave)
   );

   regincr_window_accum #(.DATA_W(8), .WIN(1), .SUM_W(16)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor for the WIN=4 instance: every output transfer pops one expectation.
   always @(negedge clk) begin
      if (reset && bus0.out_val && bus0.out_rdy) begin
         if (q0.size() == 0) begin
            chk("win4_unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = q0.pop_front();
            $display("[TB] win4 result sum=%0d max=%0d (exp %0d/%0d)",
                     bus0.out_sum, bus0.out_max, e.sum, e.max);
            chk("win4_sum", int'(bus0.out_sum), e.sum);
            chk("win4_max", int'(bus0.out_max), e.max);
         end
      end
   end

   // Monitor for the WIN=1 instance.
   always @(negedge clk) begin
      if (reset && bus1.out_val && bus1.out_rdy) begin
         if (q1.size() == 0) begin
            chk("win1_unexpected_output", 1, 0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            $display("[TB] win1 result sum=%0d max=%0d (exp %0d/%0d)",
                     bus1.out_sum, bus1.out_max, e.sum, e.max);
            chk("win1_sum", int'(bus1.out_sum), e.sum);
            chk("win1_max", int'(bus1.out_max), e.max);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [7:0] m);
      bus0.in_val = 1'b1;
      bus0.in_msg = m;
      step();
      bus0.in_val = 1'b0;
   endtask

   task automatic send1(input logic [7:0] m);
      bus1.in_val = 1'b1;
      bus1.in_msg = m;
      step();
      bus1.in_val = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
         step();
         n++;
      end
      chk(name, q0.size() + q1.size(), 0);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b0;
      bus0.in_val = 1'b0; bus0.in_msg = '0; bus0.out_rdy = 1'b1;
      bus1.in_val = 1'b0; bus1.in_msg = '0; bus1.out_rdy = 1'b1;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_val", int'(bus0.out_val), 0);
      chk("rst_in_rdy",  int'(bus0.in_rdy), 1);
      chk("rst_busy",    int'(bus0.busy), 0);
      chk("rst_out_sum", int'(bus0.out_sum), 0);
      chk("rst_out_max", int'(bus0.out_max), 0);
      reset = 1'b1;
      step();

      // Basic window 1,2,3,4.
      q0.push_back('{sum: 10, max: 4});
      send0(8'd1); send0(8'd2); send0(8'd3);
      chk("basic_busy", int'(bus0.busy), 1);
      send0(8'd4);
      chk("basic_latency_out_val", int'(bus0.out_val), 1);
      step();
      chk("basic_idle_out_val", int'(bus0.out_val), 0);
      chk("basic_idle_busy", int'(bus0.busy), 0);
      drain("basic_drain");

      // Backpressure on window 5,9,2,7; a stalled sample must not be taken.
      bus0.out_rdy = 1'b0;
      q0.push_back('{sum: 23, max: 9});
      send0(8'd5); send0(8'd9); send0(8'd2); send0(8'd7);
      for (int i = 0; i < 3; i++) begin
         bus0.in_val = 1'b1;
         bus0.in_msg = 8'd50;
         #1;
         chk("bp_out_val", int'(bus0.out_val), 1);
         chk("bp_out_sum", int'(bus0.out_sum), 23);
         chk("bp_out_max", int'(bus0.out_max), 9);
         chk("bp_in_rdy",  int'(bus0.in_rdy), 0);
         step();
      end
      bus0.in_val = 1'b0;
      bus0.out_rdy = 1'b1;
      #1;
      chk("bp_in_rdy_follows", int'(bus0.in_rdy), 1);
      step();
      chk("bp_after_out_val", int'(bus0.out_val), 0);
      chk("bp_after_in_rdy", int'(bus0.in_rdy), 1);
      drain("bp_drain");

      // Back-to-back: 10,20,30,40 then 9 accepted in DONE starts 9,3,8,1.
      q0.push_back('{sum: 100, max: 40});
      send0(8'd10); send0(8'd20); send0(8'd30); send0(8'd40);
      chk("b2b_done", int'(bus0.out_val), 1);
      send0(8'd9);
      chk("b2b_busy", int'(bus0.busy), 1);
      chk("b2b_out_val", int'(bus0.out_val), 0);
      chk("b2b_new_sum", int'(bus0.out_sum), 9);
      q0.push_back('{sum: 21, max: 9});
      send0(8'd3); send0(8'd8); send0(8'd1);
      drain("b2b_drain");

      // Max values with in_val gaps: only four accepts.
      q0.push_back('{sum: 1020, max: 255});
      for (int i = 0; i < 8; i++) begin
         bus0.in_val = (i % 2 == 0);
         bus0.in_msg = 8'd255;
         step();
      end
      bus0.in_val = 1'b0;
      drain("gap_drain");
      chk("gap_idle", int'(bus0.busy), 0);

      // Asynchronous reset in the middle of a window.
      send0(8'd3); send0(8'd6);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy",    int'(bus0.busy), 0);
      chk("arst_out_val", int'(bus0.out_val), 0);
      chk("arst_out_sum", int'(bus0.out_sum), 0);
      chk("arst_out_max", int'(bus0.out_max), 0);
      step();
      reset = 1'b1;
      step();
      q0.push_back('{sum: 4, max: 1});
      send0(8'd1); send0(8'd1); send0(8'd1); send0(8'd1);
      drain("arst_drain");

      // WIN=1 instance: each sample is a window, at full throughput.
      q1.push_back('{sum: 200, max: 200});
      q1.push_back('{sum: 7, max: 7});
      q1.push_back('{sum: 13, max: 13});
      send1(8'd200);
      chk("win1_latency_out_val", int'(bus1.out_val), 1);
      chk("win1_busy", int'(bus1.busy), 0);
      send1(8'd7);
      send1(8'd13);
      drain("win1_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
